soc_bram_dma: RTL

- Bus-initiator copy engine that drives the SoC BRAM controller's request port (addr/rw/valid/dwrite in, dread/done back).
- Copies N 32-bit words from a source byte address to a destination byte address, one read then one write per word.
- Started by a one-cycle command pulse. Lets software-less test logic and boot code move data in on-chip RAM without the CPU.

---
 rtl/soc_bram_dma.sv | 115 +++++++++++
 1 files changed

// File: rtl/soc_bram_dma.sv
// Word-copy DMA engine mastering the BRAM controller request port.
// One read then one write per 32-bit word; a start pulse launches a job and irq pulses at completion.
module soc_bram_dma #(
  parameter int addr_width   = 8,
  parameter int len_width    = 8,
  parameter int drain_cycles = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] src,
  input  logic [addr_width-1:0] dst,
  input  logic [len_width-1:0]  len,
  output logic                  busy,
  output logic                  irq,
  output logic [addr_width-1:0] bus_addr,
  output logic [31:0]           bus_dwrite,
  output logic                  bus_rw,
  output logic                  bus_valid,
  input  logic [31:0]           bus_dread,
  input  logic                  bus_done
);

  localparam int DRAIN_W = (drain_cycles < 2) ? 1 : $clog2(drain_cycles + 1);
  localparam logic [addr_width-1:0] WORD_STEP = addr_width'(4);

  typedef enum logic [1:0] {S_DRAIN, S_IDLE, S_READ, S_WRITE} state_t;

  state_t                state, state_next;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic [addr_width-1:0] src_ptr, dst_ptr;
  logic [len_width-1:0]  count;
  logic                  last_word;

  assign last_word = (count == len_width'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_DRAIN;
    else     state <= state_next;
  end

  // The responder has no reset, so DRAIN lets any op it still holds run out before we drive the bus.
  always_comb begin
    state_next = state;
    case (state)
      S_DRAIN: if (drain_cnt <= DRAIN_W'(1)) state_next = S_IDLE;
      S_IDLE:  if (start && (len != '0)) state_next = S_READ;
      S_READ:  if (bus_done) state_next = S_WRITE;
      S_WRITE: if (bus_done) state_next = last_word ? S_IDLE : S_READ;
      default: state_next = S_DRAIN;
    endcase
  end

  // Bus request fields only move on a sampled bus_done, keeping them stable for the responder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt  <= DRAIN_W'(drain_cycles);
      src_ptr    <= '0;
      dst_ptr    <= '0;
      count      <= '0;
      busy       <= 1'b0;
      irq        <= 1'b0;
      bus_valid  <= 1'b0;
      bus_rw     <= 1'b0;
      bus_addr   <= '0;
      bus_dwrite <= '0;
    end else begin
      irq <= 1'b0;
      case (state)
        S_DRAIN: begin
          if (drain_cnt != '0) drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              irq <= 1'b1;
            end else begin
              src_ptr   <= src;
              dst_ptr   <= dst;
              count     <= len;
              busy      <= 1'b1;
              bus_valid <= 1'b1;
              bus_rw    <= 1'b0;
              bus_addr  <= src;
            end
          end
        end
        S_READ: begin
          if (bus_done) begin
            bus_dwrite <= bus_dread;
            bus_addr   <= dst_ptr;
            bus_rw     <= 1'b1;
            src_ptr    <= src_ptr + WORD_STEP;
          end
        end
        S_WRITE: begin
          if (bus_done) begin
            dst_ptr <= dst_ptr + WORD_STEP;
            count   <= count - len_width'(1);
            bus_rw  <= 1'b0;
            if (last_word) begin
              bus_valid <= 1'b0;
              busy      <= 1'b0;
              irq       <= 1'b1;
            end else begin
              bus_addr <= src_ptr;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
